cache_req_arbiter6: RTL
=======================

CACHE_REQ_ARBITER6 -- requirements
Module: cache_req_arbiter6

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning WAIT-state cycles before forced release (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have port i_req, input, 6, level request per requester 0..5.
REQ-005 The block SHALL have port i_prio_en, input, 1, fixed priority for requester 0 when high.
REQ-006 The block SHALL have port o_gnt, output, 6, one-hot grant, held for the whole transaction.
REQ-007 The block SHALL have port o_sel, output, 6, one-hot select to the 6-way cache selector valid inputs; always equal to o_gnt.
REQ-008 The block SHALL have port o_drive, output, 1, single-cycle launch pulse to the selector.
REQ-009 The block SHALL have port i_free, input, 1, completion pulse from downstream; OR of the selector's six free returns.
REQ-010 The block SHALL have port o_busy, output, 1, high in any state other than IDLE.
REQ-011 The block SHALL have port o_last_id, output, 3, index 0..5 of the most recently released grant.
REQ-012 The block SHALL have port o_timeout, output, 1, single-cycle pulse on forced release.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ISSUE and WAIT; all outputs SHALL be registered or decoded from state and registers only.
REQ-014 In IDLE with i_req != 0, the block SHALL latch a winner into o_gnt/o_sel and move to ISSUE on the same edge; with i_req == 0 it SHALL stay in IDLE.
REQ-015 Winner selection SHALL be: if i_prio_en and i_req[0], requester 0; else the first set i_req bit searching from pointer rr_ptr upward, wrapping 5 -> 0.
REQ-016 rr_ptr SHALL be a 3-bit register with value range 0..5, and SHALL never hold 6 or 7.
REQ-017 In ISSUE, o_drive SHALL be 1 for exactly one cycle; the next state SHALL be WAIT unconditionally.
REQ-018 Latency: i_req sampled in IDLE at cycle N SHALL produce o_gnt, o_sel and o_drive visible in cycle N+1.
REQ-019 In WAIT, a cycle counter (8 bits) SHALL increment from 0 each cycle; on i_free=1 the block SHALL release.
REQ-020 In WAIT, if the counter reaches TIMEOUT_CYCLES-1 without i_free, the block SHALL release and pulse o_timeout in the cycle after the release edge.
REQ-021 If i_free and the timeout condition occur in the same cycle, i_free SHALL win and o_timeout SHALL stay 0.
REQ-022 Release SHALL clear o_gnt/o_sel to 0, set o_last_id to the winner, set rr_ptr = (winner+1) mod 6 (5 -> 0), clear the counter, and return to IDLE.
REQ-023 A grant to requester 0 via priority SHALL also update rr_ptr per REQ-022.
REQ-024 i_free in IDLE or ISSUE SHALL be ignored.
REQ-025 Changes on i_req or i_prio_en while in ISSUE or WAIT SHALL NOT alter o_gnt, including deassertion by the granted requester.
REQ-026 Back-to-back throughput SHALL be one transaction per minimum 3 cycles (IDLE, ISSUE, WAIT with i_free in the first WAIT cycle).

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, o_gnt=0, o_sel=0, o_drive=0, o_busy=0, o_timeout=0, o_last_id=0, rr_ptr=0, counter=0, from any state including mid-WAIT.
REQ-028 An i_free arriving in the cycle after a reset-aborted transaction SHALL be ignored per REQ-024.

Verification
REQ-029 Single request: i_req=6'b000100 after reset -> next cycle o_gnt=o_sel=6'b000100, o_drive=1; i_free two cycles later -> o_gnt=0, o_last_id=2, rr_ptr=3.
REQ-030 Round robin: i_req=6'b111111 held, i_free in every first WAIT cycle -> grant order 0,1,2,3,4,5,0, one grant per 3 cycles.
REQ-031 Priority: rr_ptr=3, i_req=6'b001001, i_prio_en=1 -> grant 0; with i_prio_en=0 -> grant 3.
REQ-032 Timeout: TIMEOUT_CYCLES=4, grant 1, no i_free -> release after 4 WAIT cycles, o_timeout=1 for one cycle, rr_ptr=2; repeat with i_free on the 4th WAIT cycle -> o_timeout stays 0.
REQ-033 Reset mid-WAIT: grant 5, assert rst for one cycle -> all outputs 0, rr_ptr=0; i_free in the next cycle is ignored.
REQ-034 Wrap and stability: rr_ptr=5, i_req=6'b100001 -> grant 5 then 0; i_req toggling during WAIT leaves o_gnt unchanged.

Source files
------------

// File: rtl/cache_req_arbiter6.sv
// rtl/cache_req_arbiter6.sv - six-way cache request arbiter with priority, round robin and timeout release
//
// Purpose:
//   Grants one of six requesters at a time to a 6-way cache selector.
//   A grant is issued from IDLE, the selector gets a single launch pulse in
//   ISSUE, and the grant is held in WAIT until the downstream completion
//   pulse arrives or the WAIT counter expires.
//
// Ports:
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   i_req      : [5:0] level request per requester
//   i_prio_en  : requester 0 wins outright when high and requesting
//   i_free     : completion pulse from downstream (ignored outside WAIT)
//   o_gnt      : [5:0] one-hot grant, held for the whole transaction
//   o_sel      : [5:0] one-hot select to the cache selector, equal to o_gnt
//   o_drive    : single-cycle launch pulse (high in ISSUE)
//   o_busy     : high whenever the arbiter is not in IDLE
//   o_last_id  : [2:0] index of the most recently released grant
//   o_timeout  : single-cycle pulse after a forced release

module cache_req_arbiter6 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_req,
    input  logic       i_prio_en,
    input  logic       i_free,
    output logic [5:0] o_gnt,
    output logic [5:0] o_sel,
    output logic       o_drive,
    output logic       o_busy,
    output logic [2:0] o_last_id,
    output logic       o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Counter value on which a WAIT cycle without i_free forces release.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     r_state;
    logic [5:0] r_gnt;
    logic [2:0] r_winner;
    logic [2:0] r_last_id;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;
    logic       r_timeout;

    state_t     w_state_nxt;
    logic [5:0] w_gnt_nxt;
    logic [2:0] w_winner_nxt;
    logic [2:0] w_last_id_nxt;
    logic [2:0] w_ptr_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_timeout_nxt;

    logic       w_found;
    logic [2:0] w_win;
    logic [3:0] w_sum;
    logic [2:0] w_ptr_after;

    // Winner search: priority override for requester 0, otherwise the first
    // set request at or above rr_ptr, wrapping 5 -> 0. The modulo-6 sum is
    // formed in 4 bits so ptr+offset never aliases before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sum   = 4'd0;
        if (i_prio_en && i_req[0]) begin
            w_found = 1'b1;
            w_win   = 3'd0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                w_sum = {1'b0, r_ptr} + 4'(k);
                if (w_sum >= 4'd6) begin
                    w_sum = w_sum - 4'd6;
                end
                if (!w_found && i_req[w_sum[2:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_sum[2:0];
                end
            end
        end
    end

    // Pointer value after releasing the current winner.
    always_comb begin
        w_ptr_after = (r_winner == 3'd5) ? 3'd0 : r_winner + 3'd1;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_winner_nxt  = r_winner;
        w_last_id_nxt = r_last_id;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt    = 6'b000001 << w_win;
                    w_winner_nxt = w_win;
                    w_cnt_nxt    = 8'd0;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // i_free takes precedence over an expiring counter, so a
                // completion on the last allowed cycle is not a timeout.
                if (i_free || (r_cnt == LP_CNT_LAST)) begin
                    w_timeout_nxt = ~i_free;
                    w_gnt_nxt     = 6'b000000;
                    w_last_id_nxt = r_winner;
                    w_ptr_nxt     = w_ptr_after;
                    w_cnt_nxt     = 8'd0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 6'b000000;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_gnt     <= 6'b000000;
            r_winner  <= 3'd0;
            r_last_id <= 3'd0;
            r_ptr     <= 3'd0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_winner  <= w_winner_nxt;
            r_last_id <= w_last_id_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_sel     = r_gnt;
    assign o_drive   = (r_state == ISSUE);
    assign o_busy    = (r_state != IDLE);
    assign o_last_id = r_last_id;
    assign o_timeout = r_timeout;

endmodule
